// File: rtl/cache_bus_pkg.sv
// Shared definitions for the line-granular backing memory model:
// FSM state encoding and width derivations from the bus geometry.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_WR_WAIT
    } state_e;

    function automatic int unsigned line_w(input int unsigned word_w,
                                           input int unsigned line_words);
        return word_w * line_words;
    endfunction

    function automatic int unsigned off_w(input int unsigned word_w,
                                          input int unsigned line_words);
        return $clog2(word_w * line_words / 8);
    endfunction

    function automatic int unsigned idx_w(input int unsigned mem_lines);
        return $clog2(mem_lines);
    endfunction

    function automatic int unsigned beat_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Full-line backing store: one synchronous full-line write port and one
// asynchronous read port. Contents power up to line L word w = L*LINE_WORDS+w.
module mem_line_array
    import cache_bus_pkg::*;
#(
    parameter  int unsigned WORD_W     = 32,
    parameter  int unsigned LINE_WORDS = 4,
    parameter  int unsigned MEM_LINES  = 256,
    localparam int unsigned LINE_W     = line_w(WORD_W, LINE_WORDS),
    localparam int unsigned IDX_W      = idx_w(MEM_LINES)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    function automatic logic [LINE_W-1:0] init_line(input int unsigned l);
        logic [LINE_W-1:0] v;
        v = '0;
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            v[w*WORD_W +: WORD_W] = WORD_W'(l * LINE_WORDS + w);
        end
        return v;
    endfunction

    logic [LINE_W-1:0] lines [MEM_LINES];

    // Power-up contents come from the declaration initialiser; reset never touches storage.
    for (genvar L = 0; L < MEM_LINES; L++) begin : g_line
        logic [LINE_W-1:0] line_q = init_line(L);

        always_ff @(posedge clk) begin
            if (we_i && (waddr_i == IDX_W'(L))) begin
                line_q <= wdata_i;
            end
        end

        assign lines[L] = line_q;
    end

    assign rdata_o = lines[raddr_i];

endmodule

// File: rtl/cache_mem_model.sv
// Line-granular memory model behind the Dcache: one line write or one line
// read at a time, reads returned as a word burst after RD_LATENCY cycles.
module cache_mem_model
    import cache_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned MEM_LINES  = 256,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned WR_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_rdy,
    output logic                         ret_valid,
    output logic                         ret_last,
    output logic [WORD_W-1:0]            ret_data,
    input  logic                         wr_req,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WORD_W*LINE_WORDS-1:0] wr_data,
    output logic                         wr_rdy,
    output logic                         wr_done,
    output logic [15:0]                  rd_count,
    output logic [15:0]                  wr_count
);

    localparam int unsigned LINE_W = line_w(WORD_W, LINE_WORDS);
    localparam int unsigned OFF_W  = off_w(WORD_W, LINE_WORDS);
    localparam int unsigned IDX_W  = idx_w(MEM_LINES);
    localparam int unsigned BEAT_W = beat_w(LINE_WORDS);

    state_e              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]    ridx_q, ridx_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic                ret_valid_q, ret_valid_d;
    logic                ret_last_q, ret_last_d;
    logic [WORD_W-1:0]   ret_data_q, ret_data_d;
    logic                wr_done_q, wr_done_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic                mem_we;
    logic [LINE_W-1:0]   mem_rdata;
    logic                unused_addr;

    // Offset and aliasing upper address bits are intentionally dropped.
    assign unused_addr = ^{rd_addr, wr_addr};

    mem_line_array #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .MEM_LINES  (MEM_LINES)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (widx_q),
        .wdata_i (wline_q),
        .raddr_i (ridx_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            ridx_q      <= '0;
            widx_q      <= '0;
            wline_q     <= '0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            ret_data_q  <= '0;
            wr_done_q   <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            ridx_q      <= ridx_d;
            widx_q      <= widx_d;
            wline_q     <= wline_d;
            ret_valid_q <= ret_valid_d;
            ret_last_q  <= ret_last_d;
            ret_data_q  <= ret_data_d;
            wr_done_q   <= wr_done_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        ridx_d      = ridx_q;
        widx_d      = widx_q;
        wline_d     = wline_q;
        ret_valid_d = 1'b0;
        ret_last_d  = 1'b0;
        ret_data_d  = ret_data_q;
        wr_done_d   = 1'b0;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A simultaneous read stays pending; the requester keeps rd_req asserted.
                if (wr_req) begin
                    widx_d     = wr_addr[OFF_W +: IDX_W];
                    wline_d    = wr_data;
                    cnt_d      = '0;
                    wr_count_d = wr_count_q + 16'd1;
                    state_d    = ST_WR_WAIT;
                end else if (rd_req) begin
                    ridx_d     = rd_addr[OFF_W +: IDX_W];
                    cnt_d      = '0;
                    beat_d     = '0;
                    rd_count_d = rd_count_q + 16'd1;
                    state_d    = (RD_LATENCY == 0) ? ST_RD_BURST : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == 32'(RD_LATENCY - 1)) begin
                    state_d = ST_RD_BURST;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RD_BURST: begin
                ret_valid_d = 1'b1;
                ret_data_d  = mem_rdata[beat_q*WORD_W +: WORD_W];
                beat_d      = beat_q + 1'b1;
                if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
                    ret_last_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_q == 32'(WR_LATENCY - 1)) begin
                    mem_we    = 1'b1;
                    wr_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_rdy    = (state_q == ST_IDLE);
    assign wr_rdy    = (state_q == ST_IDLE);
    assign ret_valid = ret_valid_q;
    assign ret_last  = ret_last_q;
    assign ret_data  = ret_data_q;
    assign wr_done   = wr_done_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule
